i2c_reg_arbiter: RTL
====================

Name: i2c_reg_arbiter

Overview:
Shares the single-port register bank behind i2c_slave_top between two requesters. One is the I2C slave byte engine, which issues single-cycle read/write strobes and cannot stall. The other is a local fabric port with a req/gnt handshake, used by on-chip logic to update status and read configuration. The block buffers one pending I2C access, arbitrates round-robin, drives the RAM port with registered outputs, and routes read data back to the owner with a fixed latency. It sits between the I2C slave core and the register RAM inside i2c_slave_top.

Parameters:
ADDR_W, 8, register address width (bank depth 2**ADDR_W).
DATA_W, 8, register data width.
RO_BASE, 8'h80, addresses >= RO_BASE are read-only from I2C and writable only from the local port.

Ports:
clk  input  1  system clock.
reset  input  1  synchronous, active-high reset.
i2c_wr_stb  input  1  single-cycle write strobe from slave core.
i2c_rd_stb  input  1  single-cycle read strobe from slave core.
i2c_addr  input  ADDR_W  register address, valid with strobe.
i2c_wdata  input  DATA_W  write data, valid with i2c_wr_stb.
i2c_rdata  output  DATA_W  read data to slave core.
i2c_rvalid  output  1  one-cycle pulse, i2c_rdata valid.
i2c_overrun  output  1  sticky: strobe arrived while pending slot still occupied.
i2c_proto_err  output  1  sticky: rd and wr strobe in same cycle, or I2C write to RO region.
loc_req  input  1  local access request; held until loc_gnt.
loc_we  input  1  1 = write, 0 = read.
loc_addr  input  ADDR_W  local address.
loc_wdata  input  DATA_W  local write data.
loc_gnt  output  1  combinational; access accepted this cycle.
loc_rdata  output  DATA_W  local read data.
loc_rvalid  output  1  one-cycle pulse, loc_rdata valid.
mem_en  output  1  RAM access enable (registered).
mem_we  output  1  RAM write enable (registered).
mem_addr  output  ADDR_W  RAM address (registered).
mem_wdata  output  DATA_W  RAM write data (registered).
mem_rdata  input  DATA_W  RAM read data, valid the cycle after mem_en and !mem_we.

Behaviour:
- Reset: every output 0. Pending slot empty, rr pointer = I2C, read pipeline flushed. A reset mid-operation drops any pending access and any in-flight read (no rvalid issued). Both sticky flags clear.
- Pending slot: a strobe in cycle N is captured at the end of N (addr, wdata, op). Slot is eligible for arbitration from N+1.
- Arbiter states: IDLE (no requester), GNT_I2C, GNT_LOC. Each is evaluated combinationally every cycle. Every grant lasts exactly one cycle.
- Only one candidate: that candidate wins.
- Both candidates: the one not granted last wins (rr pointer). The pointer updates only on a grant. Worst-case I2C wait is therefore 2 cycles from strobe.
- loc_gnt is high in the decision cycle D. The local master may change req/addr in D+1.
- Memory access: the winner's access appears on mem_* in D+1.
- Read data: mem_rdata is sampled in D+2 and registered into the owner's rdata. rvalid pulses in D+3. Fixed read latency from decision is 3 cycles. Back-to-back grants are allowed every cycle.
- An owner tag travels with each read through the pipeline. Non-owner rdata holds its last value.
- Write in D: no rvalid.
- I2C write to address >= RO_BASE: mem_en pulses with mem_we = 0 (dummy), no rvalid, i2c_proto_err set.
- I2C reads of the RO region are permitted.
- rd and wr strobe in the same cycle: the write is captured, the read is discarded, i2c_proto_err set.
- Strobe while slot is occupied and not granted this cycle: new access overwrites the slot, i2c_overrun set.
- Strobe in the same cycle the slot is granted: new access is captured, no overrun.
- Address wrap: none. Addresses are used as given, width ADDR_W.

Decomposition:
- i2c_reg_pkg: op enum (OP_RD, OP_WR), owner enum (OWN_I2C, OWN_LOC), arbiter state enum, pending-slot struct {valid, op, addr, wdata}.
- One sub-module: i2c_reg_rd_pipe. It is the 2-stage owner-tag/read-return pipeline producing the *_rdata and *_rvalid outputs.
- Arbiter and pending slot stay in the top module.

Test Plan:
- I2C write 0x03 <- 0x7B, no local traffic -> mem_en = mem_we = 1, addr 0x03, data 0x7B in cycle strobe+2. Then I2C read 0x03 -> i2c_rvalid pulses at strobe+4 with i2c_rdata = 0x7B.
- Local read of 0x8F held with loc_req while the I2C slot is idle -> loc_gnt in the same cycle; loc_rvalid 3 cycles later with RAM contents of 0x8F.
- Contention: loc_req held continuously (write 0x01 <- 0xCB) plus I2C write 0x01 <- 0x7A strobe -> grants alternate per rr pointer. Final RAM[0x01] equals the later-granted write. The I2C grant arrives within 2 cycles of the strobe.
- RO protection: I2C write 0x82 <- 0x7A -> no RAM write; i2c_proto_err = 1 and stays set. Local write 0x82 <- 0x55 then I2C read 0x82 -> 0x55.
- Overrun: two I2C strobes 1 cycle apart while the local port holds the grant -> i2c_overrun = 1, only the second access executes. A simultaneous rd+wr strobe -> write executes, i2c_proto_err = 1.
- Reset asserted 1 cycle after an I2C read grant -> no i2c_rvalid, all outputs 0 the cycle after reset, normal operation resumes after release.

Source files
------------

// File: rtl/i2c_reg_pkg.sv
// Shared types for the I2C register-bank arbiter: access op, read-data owner,
// arbiter decision states and the single-entry pending I2C slot.
package i2c_reg_pkg;

    // Default bank geometry; the pending-slot fields are sized from these.
    localparam int REG_ADDR_W = 8;
    localparam int REG_DATA_W = 8;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    typedef enum logic {
        OWN_I2C = 1'b0,
        OWN_LOC = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GNT_I2C = 2'd1,
        ARB_GNT_LOC = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                  valid;
        op_e                   op;
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] wdata;
    } slot_t;

    // The requester that gets priority after `o` has been granted.
    function automatic owner_e other_owner(input owner_e o);
        return (o == OWN_I2C) ? OWN_LOC : OWN_I2C;
    endfunction

endpackage

// File: rtl/i2c_reg_rd_pipe.sv
// Read-return pipeline. A read issued in decision cycle D carries an owner tag
// through two stages (D+1 alongside the RAM access, D+2 while RAM data is
// valid); the RAM data is then registered into the owner's rdata and the
// owner's rvalid pulses in D+3. The other owner's rdata is left untouched.
module i2c_reg_rd_pipe
    import i2c_reg_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_vld,
    input  owner_e            issue_owner,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] i2c_rdata,
    output logic              i2c_rvalid,
    output logic [DATA_W-1:0] loc_rdata,
    output logic              loc_rvalid
);

    logic   s_vld_q [2];
    logic   s_vld_d [2];
    owner_e s_own_q [2];
    owner_e s_own_d [2];

    logic [DATA_W-1:0] rdata_q  [2];
    logic [DATA_W-1:0] rdata_d  [2];
    logic              rvalid_q [2];
    logic              rvalid_d [2];

    // Tag shift: stage 0 follows the decision, stage 1 follows stage 0.
    always_comb begin
        s_vld_d[0] = issue_vld;
        s_own_d[0] = issue_owner;
        s_vld_d[1] = s_vld_q[0];
        s_own_d[1] = s_own_q[0];
    end

    // Tag registers; reset flushes any read still in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_vld_q[0] <= 1'b0;
            s_vld_q[1] <= 1'b0;
            s_own_q[0] <= OWN_I2C;
            s_own_q[1] <= OWN_I2C;
        end else begin
            s_vld_q[0] <= s_vld_d[0];
            s_vld_q[1] <= s_vld_d[1];
            s_own_q[0] <= s_own_d[0];
            s_own_q[1] <= s_own_d[1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_owner
            localparam owner_e OWN = owner_e'(gi);

            // Capture RAM data only when the tag at stage 1 names this owner.
            always_comb begin
                rvalid_d[gi] = s_vld_q[1] && (s_own_q[1] == OWN);
                rdata_d[gi]  = rvalid_d[gi] ? mem_rdata : rdata_q[gi];
            end

            // Per-owner return registers.
            always_ff @(posedge clk) begin
                if (reset) begin
                    rdata_q[gi]  <= '0;
                    rvalid_q[gi] <= 1'b0;
                end else begin
                    rdata_q[gi]  <= rdata_d[gi];
                    rvalid_q[gi] <= rvalid_d[gi];
                end
            end
        end
    endgenerate

    assign i2c_rdata  = rdata_q[0];
    assign i2c_rvalid = rvalid_q[0];
    assign loc_rdata  = rdata_q[1];
    assign loc_rvalid = rvalid_q[1];

endmodule

// File: rtl/i2c_reg_arbiter.sv
// Round-robin arbiter between the non-stallable I2C slave engine (buffered in
// a one-entry pending slot) and the local req/gnt port, driving a single-port
// register RAM through registered outputs.
module i2c_reg_arbiter
    import i2c_reg_pkg::*;
#(
    parameter int                ADDR_W  = REG_ADDR_W,
    parameter int                DATA_W  = REG_DATA_W,
    parameter logic [ADDR_W-1:0] RO_BASE = 8'h80
) (
    input  logic              clk,
    input  logic              reset,
    // I2C slave core side
    input  logic              i2c_wr_stb,
    input  logic              i2c_rd_stb,
    input  logic [ADDR_W-1:0] i2c_addr,
    input  logic [DATA_W-1:0] i2c_wdata,
    output logic [DATA_W-1:0] i2c_rdata,
    output logic              i2c_rvalid,
    output logic              i2c_overrun,
    output logic              i2c_proto_err,
    // Local fabric side
    input  logic              loc_req,
    input  logic              loc_we,
    input  logic [ADDR_W-1:0] loc_addr,
    input  logic [DATA_W-1:0] loc_wdata,
    output logic              loc_gnt,
    output logic [DATA_W-1:0] loc_rdata,
    output logic              loc_rvalid,
    // Register RAM side
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    slot_t      slot_q, slot_d;
    owner_e     rr_q, rr_d;          // requester that has priority on contention
    arb_state_e arb_state;

    logic overrun_q, overrun_d;
    logic proto_err_q, proto_err_d;

    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic   rd_issue;
    owner_e rd_owner;
    logic   gnt_i2c;
    logic   strobe;
    logic   slot_ro;

    assign strobe  = i2c_wr_stb | i2c_rd_stb;
    assign slot_ro = (slot_q.addr >= RO_BASE);

    // Decision for this cycle: lone candidate wins, otherwise rr_q picks.
    always_comb begin
        arb_state = ARB_IDLE;
        if (slot_q.valid && loc_req) begin
            arb_state = (rr_q == OWN_I2C) ? ARB_GNT_I2C : ARB_GNT_LOC;
        end else if (slot_q.valid) begin
            arb_state = ARB_GNT_I2C;
        end else if (loc_req) begin
            arb_state = ARB_GNT_LOC;
        end
    end

    assign gnt_i2c = (arb_state == ARB_GNT_I2C);
    assign loc_gnt = (arb_state == ARB_GNT_LOC);

    // Priority flips to the other requester after every grant.
    always_comb begin
        rr_d = rr_q;
        if (arb_state == ARB_GNT_I2C) begin
            rr_d = other_owner(OWN_I2C);
        end else if (arb_state == ARB_GNT_LOC) begin
            rr_d = other_owner(OWN_LOC);
        end
    end

    // Pending slot: cleared when granted, overwritten by any new strobe; a
    // write wins over a simultaneous read. Sticky error flags accumulate here.
    always_comb begin
        slot_d      = slot_q;
        overrun_d   = overrun_q;
        proto_err_d = proto_err_q;
        if (gnt_i2c) begin
            slot_d.valid = 1'b0;
        end
        if (strobe) begin
            slot_d.valid = 1'b1;
            slot_d.op    = i2c_wr_stb ? OP_WR : OP_RD;
            slot_d.addr  = i2c_addr;
            slot_d.wdata = i2c_wdata;
            if (slot_q.valid && !gnt_i2c) begin
                overrun_d = 1'b1;
            end
            if (i2c_wr_stb && i2c_rd_stb) begin
                proto_err_d = 1'b1;
            end
            if (i2c_wr_stb && (i2c_addr >= RO_BASE)) begin
                proto_err_d = 1'b1;
            end
        end
    end

    // RAM command for D+1 and read tag for the return pipeline. An I2C write
    // into the read-only region becomes a harmless dummy read with no return.
    always_comb begin
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd_issue    = 1'b0;
        rd_owner    = OWN_I2C;
        case (arb_state)
            ARB_GNT_I2C: begin
                mem_en_d    = 1'b1;
                mem_we_d    = (slot_q.op == OP_WR) && !slot_ro;
                mem_addr_d  = slot_q.addr;
                mem_wdata_d = slot_q.wdata;
                rd_issue    = (slot_q.op == OP_RD);
                rd_owner    = OWN_I2C;
            end
            ARB_GNT_LOC: begin
                mem_en_d    = 1'b1;
                mem_we_d    = loc_we;
                mem_addr_d  = loc_addr;
                mem_wdata_d = loc_wdata;
                rd_issue    = !loc_we;
                rd_owner    = OWN_LOC;
            end
            default: begin
            end
        endcase
    end

    // State and RAM-port registers; reset drops the pending access.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q      <= '0;
            rr_q        <= OWN_I2C;
            overrun_q   <= 1'b0;
            proto_err_q <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            slot_q      <= slot_d;
            rr_q        <= rr_d;
            overrun_q   <= overrun_d;
            proto_err_q <= proto_err_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_en        = mem_en_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign i2c_overrun   = overrun_q;
    assign i2c_proto_err = proto_err_q;

    i2c_reg_rd_pipe #(
        .DATA_W (DATA_W)
    ) u_rd_pipe (
        .clk         (clk),
        .reset       (reset),
        .issue_vld   (rd_issue),
        .issue_owner (rd_owner),
        .mem_rdata   (mem_rdata),
        .i2c_rdata   (i2c_rdata),
        .i2c_rvalid  (i2c_rvalid),
        .loc_rdata   (loc_rdata),
        .loc_rvalid  (loc_rvalid)
    );

endmodule
